// File: rtl/preamble_inserter.sv
// preamble_inserter
//   For each new frame, emits the short training sequence, then the long training
//   sequence with its cyclic prefix, then passes the payload through unchanged.
//   GAP_LEN zero samples follow the frame's tlast.
//   The preamble matches what the RX long-preamble detector correlates against.
//
// Ports
//   clk       clock
//   reset     synchronous, active-high
//   i_tdata   payload sample (I in upper half, Q in lower half)
//   i_tlast   last payload sample of frame
//   i_tvalid  payload valid
//   i_tready  payload accepted (only in S_PAYLOAD)
//   o_tdata   preamble, payload or gap sample
//   o_tlast   last sample of frame (payload tlast)
//   o_tvalid  output valid
//   o_tready  downstream ready
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for the first payload sample of a frame
// S_SHORT   | emitting SHORT_LEN short-preamble samples
// S_LONG    | emitting LONG_LEN long-preamble samples (CP first)
// S_PAYLOAD | zero-latency pass-through until the payload tlast
// S_GAP     | emitting GAP_LEN zero samples
module preamble_inserter #(
  parameter int WIDTH        = 32,
  parameter int SHORT_PERIOD = 16,
  parameter int SHORT_LEN    = 160,
  parameter int LONG_PERIOD  = 64,
  parameter int LONG_CP      = 32,
  parameter int LONG_LEN     = 160,
  parameter logic [WIDTH*SHORT_PERIOD-1:0] SHORT_COEFFS = '0,
  parameter logic [WIDTH*LONG_PERIOD-1:0]  LONG_COEFFS  = '0,
  parameter int GAP_LEN      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

  localparam int M1  = (SHORT_LEN > LONG_LEN) ? SHORT_LEN : LONG_LEN;
  localparam int M2  = (M1 > GAP_LEN) ? M1 : GAP_LEN;
  localparam int M3  = (M2 > 1) ? M2 : 1;
  localparam int CW  = $clog2(M3) + 1;
  localparam int SIW = (SHORT_PERIOD > 1) ? $clog2(SHORT_PERIOD) : 1;
  localparam int LIW = (LONG_PERIOD > 1) ? $clog2(LONG_PERIOD) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHORT   = 3'd1,
    S_LONG    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic            hs;
  logic [SIW-1:0]  short_idx;
  logic [LIW-1:0]  long_idx;
  logic [WIDTH-1:0] short_tab [SHORT_PERIOD];
  logic [WIDTH-1:0] long_tab  [LONG_PERIOD];

  // Unpack the coefficient vectors; entry 0 sits at the MSBs.
  for (genvar k = 0; k < SHORT_PERIOD; k++) begin : g_short_tab
    assign short_tab[k] = SHORT_COEFFS[WIDTH*(SHORT_PERIOD-1-k) +: WIDTH];
  end
  for (genvar k = 0; k < LONG_PERIOD; k++) begin : g_long_tab
    assign long_tab[k] = LONG_COEFFS[WIDTH*(LONG_PERIOD-1-k) +: WIDTH];
  end

  // The spare counter bit keeps cnt + (LONG_PERIOD - LONG_CP) from overflowing.
  // Offsetting by the CP makes the prefix the tail of the long symbol.
  assign short_idx = SIW'(cnt % CW'(SHORT_PERIOD));
  assign long_idx  = LIW'((cnt + CW'(LONG_PERIOD - LONG_CP)) % CW'(LONG_PERIOD));

  assign hs = o_tvalid & o_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        cnt <= '0;
      end else if (hs && (state == S_SHORT || state == S_LONG || state == S_GAP)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (i_tvalid) state_next = S_SHORT;
      end
      S_SHORT: begin
        if (hs && cnt == CW'(SHORT_LEN - 1)) state_next = S_LONG;
      end
      S_LONG: begin
        if (hs && cnt == CW'(LONG_LEN - 1)) state_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (hs && i_tlast) state_next = (GAP_LEN > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (hs && cnt == CW'(GAP_LEN - 1)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_tdata  = '0;
    o_tlast  = 1'b0;
    o_tvalid = 1'b0;
    i_tready = 1'b0;
    case (state)
      S_SHORT: begin
        o_tvalid = 1'b1;
        o_tdata  = short_tab[short_idx];
      end
      S_LONG: begin
        o_tvalid = 1'b1;
        o_tdata  = long_tab[long_idx];
      end
      S_PAYLOAD: begin
        o_tvalid = i_tvalid;
        o_tdata  = i_tdata;
        o_tlast  = i_tlast;
        i_tready = o_tready;
      end
      S_GAP: begin
        o_tvalid = 1'b1;
      end
      default: begin
        o_tvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_preamble_inserter.sv
module tb_preamble_inserter;

  localparam int W   = 32;
  localparam int GAP = 4;

  function automatic logic [W*16-1:0] mk_short();
    logic [W*16-1:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[W*(15-k) +: W] = {16'(k), 16'(256 + k)};
    return r;
  endfunction

  function automatic logic [W*64-1:0] mk_long();
    logic [W*64-1:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) r[W*(63-k) +: W] = {16'(64 + k), 16'(512 + k)};
    return r;
  endfunction

  localparam logic [W*16-1:0] SC = mk_short();
  localparam logic [W*64-1:0] LC = mk_long();

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] i_tdata = '0;
  logic         i_tlast = 1'b0;
  logic         i_tvalid = 1'b0;
  logic         i_tready;
  logic [W-1:0] o_tdata;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready = 1'b0;

  preamble_inserter #(
    .WIDTH(W), .SHORT_PERIOD(16), .SHORT_LEN(160), .LONG_PERIOD(64),
    .LONG_CP(32), .LONG_LEN(160), .SHORT_COEFFS(SC), .LONG_COEFFS(LC),
    .GAP_LEN(GAP)
  ) dut (
    .clk(clk), .reset(reset),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] src_data [$];
  logic         src_last [$];
  logic [W-1:0] exp_data [$];
  logic         exp_last [$];
  int           exp_kind [$];   // 0 preamble, 1 payload, 2 gap
  int           exp_idle [$];   // idle cycles expected before the sample, -1 = any
  logic [W-1:0] got [$];
  int src_ptr = 0;
  int out_ptr = 0;
  int idle_run = 0;
  int hold_at = -1;
  int hold_cnt = 0;
  bit bp_mode = 0;
  bit was_stalled = 0;
  logic [W-1:0] held_data;
  logic         held_last;
  logic         last_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (out sample %0d)", tag, obs, expv, out_ptr);
  endtask

  task automatic clear_all();
    src_data.delete(); src_last.delete();
    exp_data.delete(); exp_last.delete(); exp_kind.delete(); exp_idle.delete();
    got.delete();
    src_ptr = 0;
    out_ptr = 0;
  endtask

  task automatic push_frame(input int n, input int base, input int first_idle);
    logic [W-1:0] d;
    for (int k = 0; k < 160; k++) begin
      exp_data.push_back({16'(k % 16), 16'(256 + k % 16)});
      exp_last.push_back(1'b0); exp_kind.push_back(0);
      exp_idle.push_back(k == 0 ? first_idle : 0);
    end
    for (int j = 0; j < 160; j++) begin
      exp_data.push_back({16'(64 + (j + 32) % 64), 16'(512 + (j + 32) % 64)});
      exp_last.push_back(1'b0); exp_kind.push_back(0); exp_idle.push_back(0);
    end
    for (int i = 0; i < n; i++) begin
      d = 32'hD000_0000 | W'(base + i);
      src_data.push_back(d); src_last.push_back(i == n - 1);
      exp_data.push_back(d); exp_last.push_back(i == n - 1);
      exp_kind.push_back(1); exp_idle.push_back(0);
    end
    for (int g = 0; g < GAP; g++) begin
      exp_data.push_back('0); exp_last.push_back(1'b0);
      exp_kind.push_back(2); exp_idle.push_back(0);
    end
  endtask

  task automatic cycle();
    bit hold_now;
    @(negedge clk);
    o_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    hold_now = (src_ptr == hold_at) && (hold_cnt > 0);
    if (src_ptr < src_data.size() && !hold_now) begin
      i_tvalid = 1'b1; i_tdata = src_data[src_ptr]; i_tlast = src_last[src_ptr];
    end else begin
      i_tvalid = 1'b0; i_tdata = '0; i_tlast = 1'b0;
    end
    if (hold_now) hold_cnt--;
    #1;
    last_valid = o_tvalid;
    if (hold_now) check("stall_in_payload", i_tready, 1'b1);
    if (was_stalled) begin
      check("hold_data", o_tdata, held_data);
      check("hold_last", o_tlast, held_last);
      check("hold_valid", o_tvalid, 1'b1);
    end
    if (i_tready && out_ptr < exp_kind.size()) check("irdy_outside_payload", exp_kind[out_ptr], 1);
    if (!o_tvalid) idle_run++;
    if (o_tvalid && o_tready) begin
      if (out_ptr < exp_data.size()) begin
        check("data", o_tdata, exp_data[out_ptr]);
        check("last", o_tlast, exp_last[out_ptr]);
        if (exp_idle[out_ptr] >= 0) check("idle_before", idle_run, exp_idle[out_ptr]);
      end else begin
        check("extra_out", o_tdata, '1);
      end
      got.push_back(o_tdata);
      out_ptr++;
      idle_run = 0;
    end
    was_stalled = o_tvalid && !o_tready;
    held_data = o_tdata;
    held_last = o_tlast;
    if (i_tvalid && i_tready) src_ptr++;
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while ((out_ptr < exp_data.size() || src_ptr < src_data.size()) && n < budget) begin
      cycle();
      n++;
    end
    check("finished_in_budget", n < budget, 1'b1);
    repeat (3) cycle();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_tvalid", o_tvalid, 1'b0);
    check("rst_tlast", o_tlast, 1'b0);
    check("rst_itready", i_tready, 1'b0);

    // Ramp tables, 4-sample frame, no backpressure
    clear_all();
    push_frame(4, 0, -1);
    run_until_done(2000);
    check("t1_count", got.size(), 328);
    check("t1_out159", got[159], 32'h000F_010F);
    check("t1_out160", got[160], 32'h0060_0220);
    check("t1_out191", got[191], 32'h007F_023F);
    check("t1_out192", got[192], 32'h0040_0200);
    check("t1_out256", got[256], 32'h0040_0200);
    check("t1_out323", got[323], 32'hD000_0003);

    // Same frame under random backpressure
    clear_all();
    bp_mode = 1;
    push_frame(4, 16, -1);
    run_until_done(4000);
    bp_mode = 0;
    check("t2_count", got.size(), 328);

    // Single-sample frame, then a queued frame: one idle cycle between them
    clear_all();
    push_frame(1, 32, -1);
    push_frame(4, 48, 1);
    run_until_done(3000);
    check("t3_count", got.size(), 325 + 328);
    check("t3_d0", got[320], 32'hD000_0020);
    check("t3_next_first", got[325], 32'h0000_0100);

    // Reset in the long preamble
    clear_all();
    push_frame(4, 64, -1);
    n = 0;
    while (out_ptr < 200 && n < 1000) begin cycle(); n++; end
    check("t4_reached_200", out_ptr, 200);
    @(negedge clk);
    reset = 1'b1;
    o_tready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_all();
    was_stalled = 0;
    idle_run = 0;
    push_frame(4, 80, 1);
    cycle();
    check("t4_valid_after_rst", last_valid, 1'b0);
    run_until_done(2000);
    check("t4_first", got[0], 32'h0000_0100);
    check("t4_count", got.size(), 328);

    // Payload stall of 10 cycles
    clear_all();
    hold_at = 3;
    hold_cnt = 10;
    push_frame(8, 96, -1);
    exp_idle[323] = 10;
    run_until_done(2000);
    check("t5_hold_used", hold_cnt, 0);
    check("t5_count", got.size(), 332);
    check("t5_d3", got[323], 32'hD000_0063);
    hold_at = -1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
